mp_arith_unit: RTL and testbench
================================

# mp_arith_unit

Iterative multi-precision arithmetic unit that consumes the operand pair and command selection captured by the UART command front end and returns a registered (OPERAND_WIDTH+1)-bit result. It processes one ADDER_WIDTH-bit chunk per clock from LSB to MSB with a registered carry chain, giving add, subtract and compare on 512-bit operands with a single 128-bit adder. It sits directly downstream of the UART front end; its result feeds the byte-serial transmit path.

## Interface
- OPERAND_WIDTH, 512, operand width in bits; must be an integer multiple of ADDER_WIDTH
- ADDER_WIDTH, 128, width of the single chunk adder
- NCHUNK (localparam), OPERAND_WIDTH/ADDER_WIDTH, chunks per operation (4 by default)
- iClk  in  1  clock; one clock domain
- iRst  in  1  reset, asynchronous, active-high
- iStart  in  1  single-cycle start request, sampled only in IDLE
- iSel  in  2  operation: 01 add, 11 subtract, 10 compare, 00 null
- iOpA  in  OPERAND_WIDTH  operand A, captured on accepted iStart
- iOpB  in  OPERAND_WIDTH  operand B, captured on accepted iStart
- oRes  out  OPERAND_WIDTH+1  result; held until next accepted iStart
- oDone  out  1  one-cycle completion pulse
- oBusy  out  1  high from accepted iStart through the oDone cycle (only with MP_ARITH_BUSY_EN)

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE; oRes=0, oDone=0, oBusy=0, carry=0, chunk counter=0.
- IDLE: iStart=1 → latch iOpA, iOpB, iSel; carry-in = 1 for subtract/compare, 0 otherwise; counter=0; → CALC. iStart=0 → stay.
- CALC: each cycle compute chunk[counter] = A_chunk + (B_chunk or ~B_chunk) + carry; write into the result shadow register at bits [counter*ADDER_WIDTH +: ADDER_WIDTH]; update carry; AND the equality flag with (chunk sum == 0). Counter = NCHUNK-1 → DONE.
- DONE: load oRes from shadow per iSel, assert oDone for exactly one cycle, → IDLE.
- Add (01): oRes = A + B, full OPERAND_WIDTH+1 bits, oRes[OPERAND_WIDTH] = final carry.
- Subtract (11): oRes[OPERAND_WIDTH-1:0] = (A − B) mod 2^OPERAND_WIDTH; oRes[OPERAND_WIDTH] = borrow = ~final carry (1 iff A < B unsigned).
- Compare (10): oRes[OPERAND_WIDTH] = (A < B); oRes[OPERAND_WIDTH-1] = (A == B); all other bits 0.
- Null (00): runs full latency, oRes = 0, oDone pulses (prevents caller hang).
- iStart in CALC or DONE ignored; operands and iSel changing after acceptance have no effect.
- Reset mid-operation: immediate abort to IDLE, oRes cleared, no oDone.

## Timing
- iStart high in cycle 0 (accepted) → CALC in cycles 1..NCHUNK → oDone high in cycle NCHUNK+1 (cycle 5 by default), oRes valid from that same cycle.
- Earliest next accepted iStart: cycle NCHUNK+2.
- Throughput: one operation per NCHUNK+2 cycles.
- Critical path: one ADDER_WIDTH-bit adder plus operand mux; no combinational path input→output.
- oDone and oRes are registered outputs.

## Configuration
- MP_ARITH_BUSY_EN defined: oBusy port present, high from cycle 1 through the oDone cycle inclusive, 0 in IDLE and after reset.
- Not defined: oBusy port absent; all other behaviour identical.

## Structure
- Package mp_arith_pkg: iSel encodings (SEL_NULL=00, SEL_ADD=01, SEL_CMP=10, SEL_SUB=11) and state encodings; shared with the UART front end's command decoder.
- Sub-module mp_chunk_adder: combinational ADDER_WIDTH-bit adder with carry-in, optional B inversion, sum and carry-out; one instance.
- Top holds FSM, counter, carry, equality flag, operand and shadow registers.

## Test plan
- Add A=2^512−1, B=1, iSel=01 → oDone in cycle 5, oRes = 1 followed by 512 zeros (carry ripples through all 4 chunks).
- Subtract A=5, B=7, iSel=11 → oRes[511:0] = 2^512−2, oRes[512]=1.
- Compare A=B=0xDEAD…(random 512-bit), iSel=10 → oRes[512]=0, oRes[511]=1, rest 0; then A=3, B=4 → oRes[512]=1, oRes[511]=0.
- iStart re-pulsed in cycles 2 and 5 with different operands → ignored; first result unchanged, single oDone.
- iRst asserted in cycle 3 of an add → oRes=0, oDone never pulses; new iStart after reset completes correctly.
- iSel=00 → oDone in cycle 5, oRes=0; with MP_ARITH_BUSY_EN, oBusy high exactly cycles 1–5.

Source files
------------

// File: rtl/mp_arith_pkg.sv
// Shared encodings for the multi-precision arithmetic unit and its command decoder.
package mp_arith_pkg;

  typedef enum logic [1:0] {
    SEL_NULL = 2'b00,
    SEL_ADD  = 2'b01,
    SEL_CMP  = 2'b10,
    SEL_SUB  = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mp_arith_if.sv
// Command/result bus of mp_arith_unit. oBusy exists only with MP_ARITH_BUSY_EN.
interface mp_arith_if #(
  parameter int OPERAND_WIDTH = 512
);
  logic                     iStart;
  logic [1:0]               iSel;
  logic [OPERAND_WIDTH-1:0] iOpA;
  logic [OPERAND_WIDTH-1:0] iOpB;
  logic [OPERAND_WIDTH:0]   oRes;
  logic                     oDone;
`ifdef MP_ARITH_BUSY_EN
  logic                     oBusy;

  modport master (output iStart, iSel, iOpA, iOpB, input oRes, oDone, oBusy);
  modport slave  (input iStart, iSel, iOpA, iOpB, output oRes, oDone, oBusy);
`else
  modport master (output iStart, iSel, iOpA, iOpB, input oRes, oDone);
  modport slave  (input iStart, iSel, iOpA, iOpB, output oRes, oDone);
`endif
endinterface

// File: rtl/mp_chunk_adder.sv
// One ADDER_WIDTH-bit slice of the carry chain; inv selects B or ~B.
module mp_chunk_adder #(
  parameter int W = 128
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         inv,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W-1:0] bm;

  assign bm          = inv ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, bm} + (W+1)'(cin);
endmodule

// File: rtl/mp_arith_unit.sv
// Iterative add/sub/compare, one ADDER_WIDTH chunk per clock, LSB first.
// Optional oBusy output enabled by MP_ARITH_BUSY_EN.
module mp_arith_unit
  import mp_arith_pkg::*;
#(
  parameter int OPERAND_WIDTH = 512,
  parameter int ADDER_WIDTH   = 128
) (
  input logic        iClk,
  input logic        iRst,
  mp_arith_if.slave  bus
);
  localparam int NCHUNK = OPERAND_WIDTH / ADDER_WIDTH;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     carry_q, carry_d;
  logic                     eq_q, eq_d;
  sel_e                     sel_q, sel_d;
  logic [OPERAND_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OPERAND_WIDTH-1:0] shadow_q, shadow_d;
  logic [OPERAND_WIDTH:0]   res_q, res_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  logic [ADDER_WIDTH-1:0]   sum;
  logic                     cout;

  mp_chunk_adder #(.W(ADDER_WIDTH)) u_add (
    .a   (a_q[cnt_q*ADDER_WIDTH +: ADDER_WIDTH]),
    .b   (b_q[cnt_q*ADDER_WIDTH +: ADDER_WIDTH]),
    .cin (carry_q),
    .inv (sel_q[1]),
    .sum (sum),
    .cout(cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    eq_d     = eq_q;
    sel_d    = sel_q;
    a_d      = a_q;
    b_d      = b_q;
    shadow_d = shadow_q;
    res_d    = res_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: if (bus.iStart) begin
        a_d     = bus.iOpA;
        b_d     = bus.iOpB;
        sel_d   = sel_e'(bus.iSel);
        carry_d = bus.iSel[1];
        eq_d    = 1'b1;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        shadow_d[cnt_q*ADDER_WIDTH +: ADDER_WIDTH] = sum;
        carry_d = cout;
        eq_d    = eq_q & (sum == '0);
        cnt_d   = cnt_q + 1'b1;
        // Result is loaded on the last chunk so oRes and oDone land together.
        if (cnt_q == CW'(NCHUNK - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          res_d   = '0;
          case (sel_q)
            SEL_ADD: res_d = {cout, shadow_d};
            SEL_SUB: res_d = {~cout, shadow_d};
            SEL_CMP: begin
              res_d[OPERAND_WIDTH]   = ~cout;
              res_d[OPERAND_WIDTH-1] = eq_d;
            end
            default: res_d = '0;
          endcase
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      eq_q     <= 1'b0;
      sel_q    <= SEL_NULL;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      eq_q     <= eq_d;
      sel_q    <= sel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shadow_q <= shadow_d;
      res_q    <= res_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.oRes  = res_q;
  assign bus.oDone = done_q;
`ifdef MP_ARITH_BUSY_EN
  assign bus.oBusy = busy_q;
`else
  logic unused_busy;
  assign unused_busy = busy_q;
`endif
endmodule

// File: tb/tb_mp_arith_unit.sv
// Scoreboard bench for mp_arith_unit: expected results queued at issue, checked on oDone.
module tb_mp_arith_unit;
  localparam int OW     = 512;
  localparam int AW     = 128;
  localparam int NCHUNK = OW / AW;

  typedef struct {
    string         nm;
    logic [OW:0]   res;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t q[$];

  mp_arith_if #(.OPERAND_WIDTH(OW)) bus ();

  mp_arith_unit #(.OPERAND_WIDTH(OW), .ADDER_WIDTH(AW)) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [OW:0] act, input logic [OW:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // Monitor: every oDone must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.oDone) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, "_res"}, bus.oRes, e.res);
        chk({e.nm, "_cyc"}, (OW+1)'(cyc), (OW+1)'(e.cyc));
      end
    end
  end

  // Called just after a rising edge; returns one cycle later with operands scrambled.
  task automatic issue(input string nm, input logic [1:0] sel, input logic [OW-1:0] a,
                       input logic [OW-1:0] b, input logic [OW:0] exp, input bit push);
    exp_t e;
    if (push) begin
      e.nm = nm; e.res = exp; e.cyc = cyc + NCHUNK + 1;
      q.push_back(e);
    end
    bus.iStart = 1'b1; bus.iSel = sel; bus.iOpA = a; bus.iOpB = b;
    @(posedge clk); #1;
    bus.iStart = 1'b0; bus.iSel = ~sel; bus.iOpA = ~a; bus.iOpB = a;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_drain"}, (OW+1)'(q.size()), '0);
    q.delete();
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [OW-1:0] dead;
    logic [OW-1:0] one_lsh128;
    dead       = {16{32'hDEADBEEF}};
    one_lsh128 = OW'(1) << 128;
    bus.iStart = 1'b0; bus.iSel = 2'b00; bus.iOpA = '0; bus.iOpB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", bus.oRes, '0);
    chk("rst_done", (OW+1)'(bus.oDone), '0);
`ifdef MP_ARITH_BUSY_EN
    chk("rst_busy", (OW+1)'(bus.oBusy), '0);
`endif
    rst = 1'b0;
    step();

    issue("add_max_plus1", 2'b01, {OW{1'b1}}, OW'(1), {1'b1, {OW{1'b0}}}, 1'b1);
    drain("add_max_plus1");
    issue("add_chunk_carry", 2'b01, one_lsh128 - OW'(1), OW'(1), {1'b0, one_lsh128}, 1'b1);
    drain("add_chunk_carry");
    issue("sub_5_7", 2'b11, OW'(5), OW'(7), {1'b1, ~OW'(1)}, 1'b1);
    drain("sub_5_7");
    issue("sub_chunk_borrow", 2'b11, one_lsh128, OW'(1), {1'b0, one_lsh128 - OW'(1)}, 1'b1);
    drain("sub_chunk_borrow");
    issue("cmp_eq", 2'b10, dead, dead, {2'b01, {(OW-1){1'b0}}}, 1'b1);
    drain("cmp_eq");
    issue("cmp_lt", 2'b10, OW'(3), OW'(4), {2'b10, {(OW-1){1'b0}}}, 1'b1);
    drain("cmp_lt");
    issue("cmp_gt_top", 2'b10, OW'(1) << 511, OW'(1) << 510, '0, 1'b1);
    drain("cmp_gt_top");
    issue("cmp_lt_lsb", 2'b10, OW'(1) << 500, (OW'(1) << 500) | OW'(1),
          {2'b10, {(OW-1){1'b0}}}, 1'b1);
    drain("cmp_lt_lsb");

    // Null op; busy window covers cycles 1..NCHUNK+1.
`ifdef MP_ARITH_BUSY_EN
    chk("busy_c0", (OW+1)'(bus.oBusy), '0);
`endif
    issue("null", 2'b00, dead, dead, '0, 1'b1);
`ifdef MP_ARITH_BUSY_EN
    for (int i = 1; i <= NCHUNK + 2; i++) begin
      chk($sformatf("busy_c%0d", i), (OW+1)'(bus.oBusy), (OW+1)'(i <= NCHUNK + 1));
      step();
    end
`endif
    drain("null");

    // Re-pulsed iStart in cycles 2 and 5 must be ignored.
    issue("repulse", 2'b01, OW'(10), OW'(3), (OW+1)'(13), 1'b1);
    step();
    bus.iStart = 1'b1; bus.iSel = 2'b11; bus.iOpA = dead; bus.iOpB = OW'(1);
    step();
    bus.iStart = 1'b0;
    step();
    step();
    bus.iStart = 1'b1;
    step();
    bus.iStart = 1'b0;
    drain("repulse");
    repeat (8) step();

    // Reset in cycle 3 aborts: oRes cleared, no oDone.
    issue("abort", 2'b01, {OW{1'b1}}, OW'(1), '0, 1'b0);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("abort_res", bus.oRes, '0);
    chk("abort_done", (OW+1)'(bus.oDone), '0);
    step();
    rst = 1'b0;
    repeat (8) step();
    chk("abort_res_hold", bus.oRes, '0);

    issue("sub_after_rst", 2'b11, OW'(10), OW'(3), (OW+1)'(7), 1'b1);
    drain("sub_after_rst");
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
